seq_divider: RTL and testbench

//   Iterative unsigned restoring divider: the inverse of the multiplier datapath.
//   It computes quotient = dividend / divisor and remainder = dividend % divisor.
//   One quotient bit is resolved per clock using a WIDTH+1-bit trial subtraction.
//   It sits beside the multiplier as the divide unit and uses a start/busy/done handshake.

---
 rtl/seq_divider_if.sv | 21 ++
 rtl/seq_divider.sv | 99 +++++++++
 tb/tb_seq_divider.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and held results.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_out, rem_out;
    logic             busy_r, done_r, dbz_r;

    logic [WIDTH:0]   r_ext, t;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    // The shifted partial remainder keeps its carry-out bit: when it is set the
    // value exceeds any WIDTH-bit divisor, so the subtraction always succeeds
    // and its low WIDTH bits are exact.
    always_comb begin
        r_ext  = {rem, quo[WIDTH-1]};
        t      = r_ext - {1'b0, dvs};
        ge     = r_ext[WIDTH] | ~t[WIDTH];
        rem_nx = ge ? t[WIDTH-1:0] : r_ext[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            quo_out <= '0;
            rem_out <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quo_out <= '1;
                            rem_out <= bus.dividend;
                            dbz_r   <= 1'b1;
                            done_r  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            dvs    <= bus.divisor;
                            rem    <= '0;
                            quo    <= bus.dividend;
                            cnt    <= CW'(WIDTH);
                            dbz_r  <= 1'b0;
                            busy_r <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        quo_out <= quo_nx;
                        rem_out <= rem_nx;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_out;
    assign bus.remainder   = rem_out;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed table plus hand-written corner sequences for seq_divider (WIDTH=32).
module tb_seq_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Raise start until the divider shows it accepted (busy or done); returns in cycle 1.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(dif.busy || dif.done) && n < 10);
        dif.start = 1'b0;
        if (!(dif.busy || dif.done)) fail_bound("accept");
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] q,
                          output logic [W-1:0] r, output logic dbz);
        start_op(a, b);
        lat = 1;
        while (!dif.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!dif.done) fail_bound("done_wait");
        q   = dif.quotient;
        r   = dif.remainder;
        dbz = dif.div_by_zero;
    endtask

    initial begin
        int lat, dcnt, dcyc;
        logic [W-1:0] q, r, a, b, cq, cr;
        logic dbz;

        vecs[0]  = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 33};
        vecs[1]  = '{32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 33};
        vecs[3]  = '{32'd5,        32'd9,          32'd0,          32'd5,          1'b0, 33};
        vecs[4]  = '{32'd1234,     32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1, 1};
        vecs[5]  = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 33};
        vecs[6]  = '{32'h80000000, 32'h80000001,   32'd0,          32'h80000000,   1'b0, 33};
        vecs[7]  = '{32'hFFFFFFFF, 32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0, 33};
        vecs[8]  = '{32'd0,        32'd5,          32'd0,          32'd0,          1'b0, 33};
        vecs[9]  = '{32'hDEADBEEF, 32'h10,         32'h0DEADBEE,   32'hF,          1'b0, 33};
        vecs[10] = '{32'd0,        32'd0,          32'hFFFFFFFF,   32'd0,          1'b1, 1};
        vecs[11] = '{32'd1000,     32'd3,          32'd333,        32'd1,          1'b0, 33};

        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", W'(dif.busy), 0);
        chk("rst_done", W'(dif.done), 0);
        chk("rst_dbz", W'(dif.div_by_zero), 0);
        chk("rst_quo", dif.quotient, 0);
        chk("rst_rem", dif.remainder, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, q, r, dbz);
            chk($sformatf("v%0d_lat", i), W'(lat), W'(vecs[i].lat));
            chk($sformatf("v%0d_quo", i), q, vecs[i].q);
            chk($sformatf("v%0d_rem", i), r, vecs[i].r);
            chk($sformatf("v%0d_dbz", i), W'(dbz), W'(vecs[i].dbz));
            chk($sformatf("v%0d_busy_at_done", i), W'(dif.busy), 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), W'(dif.done), 0);
            repeat (3) @(posedge clk); #1;
            chk($sformatf("v%0d_hold_quo", i), dif.quotient, vecs[i].q);
            chk($sformatf("v%0d_hold_dbz", i), W'(dif.div_by_zero), W'(vecs[i].dbz));
        end

        // Start pulse with other operands during RUN must be ignored.
        start_op(32'd100, 32'd7);
        dcnt = 0; dcyc = 0; cq = '0; cr = '0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (dif.done) begin
                dcnt++;
                if (dcnt == 1) begin
                    dcyc = cyc; cq = dif.quotient; cr = dif.remainder;
                end
            end
            if (cyc == 10) begin
                dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd3;
            end else begin
                dif.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("ign_done_count", W'(dcnt), 1);
        chk("ign_done_cycle", W'(dcyc), 33);
        chk("ign_quo", cq, 32'd14);
        chk("ign_rem", cr, 32'd2);

        // Asynchronous reset mid-RUN aborts with no later done.
        start_op(32'd1000, 32'd10);
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(dif.busy), 0);
        chk("abort_done", W'(dif.done), 0);
        chk("abort_dbz", W'(dif.div_by_zero), 0);
        chk("abort_quo", dif.quotient, 0);
        chk("abort_rem", dif.remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(posedge clk); #1;
            if (dif.done || dif.busy) dcnt++;
        end
        chk("abort_no_done", W'(dcnt), 0);
        run_op(32'd1000, 32'd10, lat, q, r, dbz);
        chk("abort_re_lat", W'(lat), 33);
        chk("abort_re_quo", q, 32'd100);
        chk("abort_re_rem", r, 32'd0);

        // Random back-to-back operations against the / and % operators.
        for (int k = 0; k < 200; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 1;
            run_op(a, b, lat, q, r, dbz);
            chk($sformatf("rnd%0d_quo", k), q, a / b);
            chk($sformatf("rnd%0d_rem", k), r, a % b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
